// File: rtl/s1_feature_burst_gen_if.sv
// rtl/s1_feature_burst_gen_if.sv - request/beat handshake bundle for the S1 feature burst generator
interface s1_feature_burst_gen_if #(
    parameter int ID_W = 12
);
    // Request side: one feature-block base ID per handshake
    logic            in_valid;
    logic [ID_W-1:0] in_id;
    logic            in_ready;

    // Beat side: one lane-group address per handshake
    logic            out_valid;
    logic [ID_W-1:0] out_addr;
    logic            out_last;
    logic            out_ready;

    // Feedback to S1 and completion strobe
    logic [ID_W-1:0] last_id;
    logic            burst_done;

    // Upstream requester / downstream consumer side
    modport master (
        output in_valid,
        output in_id,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_addr,
        input  out_last,
        input  last_id,
        input  burst_done
    );

    // Burst generator side
    modport slave (
        input  in_valid,
        input  in_id,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_addr,
        output out_last,
        output last_id,
        output burst_done
    );
endinterface

// File: rtl/s1_feature_burst_gen.sv
// rtl/s1_feature_burst_gen.sv - expands an S1 base ID into a SIMD_NUM-beat lane-group address burst
module s1_feature_burst_gen #(
    parameter int ID_W        = 12,
    parameter int SIMD_NUM    = 64,
    parameter int LANE_NUM    = 32,
    parameter int FEATURE_NUM = 2048,
    parameter int CNT_W       = 6
) (
    input logic                  clk,
    input logic                  rst,
    s1_feature_burst_gen_if.slave bus
);

    // FEATURE_NUM is descriptive only; refuse to elaborate an inconsistent set
    if (FEATURE_NUM != SIMD_NUM * LANE_NUM) begin : g_feature_num_check
        $fatal(1, "FEATURE_NUM must equal SIMD_NUM*LANE_NUM");
    end

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SIMD_NUM - 1);
    localparam logic [ID_W-1:0]  STRIDE   = ID_W'(LANE_NUM);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_BURST = 1'b1
    } state_t;

    state_t          state;
    state_t          state_next;

    logic [ID_W-1:0] base;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;

    logic            out_valid_q;
    logic [ID_W-1:0] out_addr_q;
    logic            out_last_q;
    logic [ID_W-1:0] last_id_q;
    logic            burst_done_q;

    logic            beat_fire;
    logic            last_fire;
    logic            accept;
    logic            in_ready_c;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state: a final beat with a pending request chains straight into the next burst
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_next = S_BURST;
                end
            end
            S_BURST: begin
                if (last_fire && !bus.in_valid) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Handshake decode: in_ready only when the block is free or its last beat leaves now
    always_comb begin
        beat_fire  = 1'b0;
        last_fire  = 1'b0;
        in_ready_c = 1'b0;
        accept     = 1'b0;
        cnt_inc    = cnt + CNT_W'(1);
        beat_fire  = out_valid_q && bus.out_ready;
        last_fire  = beat_fire && out_last_q;
        case (state)
            S_IDLE:  in_ready_c = 1'b1;
            S_BURST: in_ready_c = last_fire;
            default: in_ready_c = 1'b0;
        endcase
        accept = bus.in_valid && in_ready_c;
    end

    // Beat datapath: outputs are registered and advance only on an accepted beat
    always_ff @(posedge clk) begin
        if (rst) begin
            base        <= '0;
            cnt         <= '0;
            out_valid_q <= 1'b0;
            out_addr_q  <= '0;
            out_last_q  <= 1'b0;
        end else if (accept) begin
            base        <= bus.in_id;
            cnt         <= '0;
            out_valid_q <= 1'b1;
            out_addr_q  <= bus.in_id;
            out_last_q  <= (CNT_LAST == '0);
        end else if (last_fire) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else if (beat_fire) begin
            cnt         <= cnt_inc;
            out_addr_q  <= out_addr_q + STRIDE;
            out_last_q  <= (cnt_inc == CNT_LAST);
        end
    end

    // Completion bookkeeping: publish the finished base and strobe for one cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            last_id_q    <= '0;
            burst_done_q <= 1'b0;
        end else begin
            burst_done_q <= last_fire;
            if (last_fire) begin
                last_id_q <= base;
            end
        end
    end

    assign bus.in_ready   = in_ready_c;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_addr   = out_addr_q;
    assign bus.out_last   = out_last_q;
    assign bus.last_id    = last_id_q;
    assign bus.burst_done = burst_done_q;

endmodule
